// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types, widths and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        CHECK,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    localparam int BYTE_WIDTH = 8;
    localparam int INSN_WIDTH = 32;
    localparam int HDR_BYTES  = 2;

    typedef logic [1:0] byte_idx_t;

    // Largest legal word count for a memory with addr_width address bits.
    function automatic logic [16:0] max_count(input int addr_width);
        return 17'd1 << addr_width;
    endfunction

endpackage

// File: rtl/imem_loader_packer.sv
// imem_loader_packer: packs little-endian bytes into a 32-bit instruction word.
//   clk, rst  clock and asynchronous active-high reset
//   clear     restart assembly at byte 0 with an empty word
//   load      accept data into the current byte lane
//   data      incoming byte
//   word      assembled word with data merged into the current lane
//   complete  load of the fourth byte; word is then the finished instruction
module imem_loader_packer
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load,
    input  logic [BYTE_WIDTH-1:0] data,
    output logic [INSN_WIDTH-1:0] word,
    output logic                  complete
);

    logic [INSN_WIDTH-1:0] acc;
    byte_idx_t             idx;

    // Merging the live byte lets the top register the finished word on the
    // same edge that accepts the last byte.
    always_comb begin
        word = acc;
        word[BYTE_WIDTH*idx +: BYTE_WIDTH] = data;
    end

    assign complete = load && idx == 2'd3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            idx <= '0;
        end else if (clear) begin
            acc <= '0;
            idx <= '0;
        end else if (load) begin
            acc <= word;
            idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot loader that writes a counted byte stream into instruction memory, then releases the CPU.
//   clk, rst      clock and asynchronous active-high reset
//   rxData        incoming byte; rxValid/rxReady handshake
//   imemWrAddr    word address, imemWrData word, imemWrEnable one-cycle strobe
//   cpuRst        CPU reset, held until the program is loaded
//   done          program loaded; error: header rejected (sticky until rst)
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_WIDTH-1:0] rxData,
    input  logic                  rxValid,
    output logic                  rxReady,
    output logic [ADDR_WIDTH-1:0] imemWrAddr,
    output logic [INSN_WIDTH-1:0] imemWrData,
    output logic                  imemWrEnable,
    output logic                  cpuRst,
    output logic                  done,
    output logic                  error
);

    state_t                state, state_next;
    logic [15:0]           count, count_next;
    logic [16:0]           word_idx, word_idx_next;
    logic                  xfer, clear, load, complete;
    logic [INSN_WIDTH-1:0] word;

    assign xfer = rxValid && rxReady;

    imem_loader_packer u_packer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .load     (load),
        .data     (rxData),
        .word     (word),
        .complete (complete)
    );

    always_comb begin
        state_next    = state;
        count_next    = count;
        word_idx_next = word_idx;
        clear         = 1'b0;
        load          = 1'b0;
        case (state)
            HDR_LO: if (xfer) begin
                count_next[7:0] = rxData;
                state_next      = HDR_HI;
            end
            HDR_HI: if (xfer) begin
                count_next[15:8] = rxData;
                state_next       = CHECK;
            end
            CHECK: begin
                word_idx_next = '0;
                clear         = 1'b1;
                state_next    = (count == 16'd0 || {1'b0, count} > max_count(ADDR_WIDTH)) ? ERROR : DATA;
            end
            DATA: begin
                load       = xfer;
                state_next = complete ? WRITE : DATA;
            end
            WRITE: begin
                state_next    = (word_idx == {1'b0, count} - 17'd1) ? DONE : DATA;
                word_idx_next = (state_next == DONE) ? word_idx : word_idx + 17'd1;
            end
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = HDR_LO;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe; error alone trails ERROR entry by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HDR_LO;
            count        <= '0;
            word_idx     <= '0;
            rxReady      <= 1'b0;
            imemWrEnable <= 1'b0;
            imemWrAddr   <= '0;
            imemWrData   <= '0;
            cpuRst       <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            word_idx     <= word_idx_next;
            rxReady      <= state_next inside {HDR_LO, HDR_HI, DATA};
            imemWrEnable <= state_next == WRITE;
            cpuRst       <= state_next != DONE;
            done         <= state_next == DONE;
            error        <= state == ERROR;
            if (complete) begin
                imemWrAddr <= word_idx[ADDR_WIDTH-1:0];
                imemWrData <= word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  rxData;
    logic        rxValid;
    logic        rxReady;
    logic [7:0]  imemWrAddr;
    logic [31:0] imemWrData;
    logic        imemWrEnable;
    logic        cpuRst;
    logic        done;
    logic        error;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          rd      = 0;
    logic [39:0] wr_log[$];
    logic [39:0] exp_q[$];
    logic [7:0]  stim[$];

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rxData       (rxData),
        .rxValid      (rxValid),
        .rxReady      (rxReady),
        .imemWrAddr   (imemWrAddr),
        .imemWrData   (imemWrData),
        .imemWrEnable (imemWrEnable),
        .cpuRst       (cpuRst),
        .done         (done),
        .error        (error)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (imemWrEnable) wr_log.push_back({imemWrAddr, imemWrData});

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_rxready", rxReady, 0);
        chk("rst_wren", imemWrEnable, 0);
        chk("rst_addr", imemWrAddr, 0);
        chk("rst_data", imemWrData, 0);
        chk("rst_cpurst", cpuRst, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rxValid = 0;
        #2 rst = 1;
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            rxValid = 0;
            @(negedge clk);
        end
        rxValid = 1;
        rxData  = b;
        n = 0;
        while (!rxReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n == 100) chk("rx_timeout", rxReady, 1);
        @(negedge clk);
        rxValid = 0;
    endtask

    task automatic send_stream(input int gap_max);
        foreach (stim[i]) send(stim[i], int'($urandom_range(gap_max, 0)));
    endtask

    task automatic load_end(input logic [7:0] addr, input logic [31:0] data);
        chk("last_wren", imemWrEnable, 1);
        chk("last_addr", imemWrAddr, addr);
        chk("last_data", imemWrData, data);
        chk("done_early", done, 0);
        chk("cpurst_held", cpuRst, 1);
        @(negedge clk);
        chk("done", done, 1);
        chk("cpurst_rel", cpuRst, 0);
        chk("rxready_done", rxReady, 0);
        chk("wren_off", imemWrEnable, 0);
    endtask

    task automatic drain();
        logic [39:0] e;
        @(negedge clk);
        #1;
        while (rd < wr_log.size()) begin
            if (exp_q.size() == 0) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_write: got %h, expected none", wr_log[rd]);
                end
            end else begin
                e = exp_q.pop_front();
                chk("write", wr_log[rd], e);
            end
            rd++;
        end
        chk("pending_writes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic hold_off(input int n, input logic exp_done);
        for (int i = 0; i < n; i++) begin
            rxValid = 1;
            rxData  = 8'($urandom);
            @(negedge clk);
            chk("held_rxready", rxReady, 0);
            chk("held_wren", imemWrEnable, 0);
            chk("held_done", done, exp_done);
            chk("held_cpurst", cpuRst, !exp_done);
        end
        rxValid = 0;
    endtask

    task automatic bad_header(input logic [7:0] lo, input logic [7:0] hi);
        stim = '{lo, hi};
        send_stream(0);
        chk("err_chk_cycle", error, 0);
        chk("chk_rxready", rxReady, 0);
        @(negedge clk);
        chk("err_k1", error, 0);
        @(negedge clk);
        chk("err_k2", error, 1);
        chk("err_cpurst", cpuRst, 1);
        hold_off(4, 0);
        chk("err_sticky", error, 1);
        drain();
    endtask

    initial begin
        int c0;
        logic [7:0]  v;
        logic [31:0] w;
        rst = 0;
        rxValid = 0;
        rxData = 0;
        #2 rst = 1;
        #1 chk_reset_vals();
        @(negedge clk);
        rst = 0;
        chk("rxready_pre", rxReady, 0);
        @(negedge clk);
        chk("rxready_rise", rxReady, 1);

        // two-word load, continuous valid
        exp_q.push_back({8'h00, 32'h12345678});
        exp_q.push_back({8'h01, 32'hDEADBEEF});
        stim = '{8'h02, 8'h00};
        send_stream(0);
        c0 = cyc;
        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream(0);
        chk("data_cycles", 40'(cyc - c0), 10);
        load_end(8'h01, 32'hDEADBEEF);
        drain();

        // bytes offered after done are neither consumed nor written
        hold_off(6, 1);
        drain();

        // same stream with random idle gaps
        do_reset();
        exp_q.push_back({8'h00, 32'h12345678});
        exp_q.push_back({8'h01, 32'hDEADBEEF});
        stim = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_stream(3);
        load_end(8'h01, 32'hDEADBEEF);
        drain();

        // zero and oversize counts
        do_reset();
        bad_header(8'h00, 8'h00);
        do_reset();
        bad_header(8'h01, 8'h01);

        // full-capacity load of 256 words
        do_reset();
        stim = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            v = i[7:0];
            w = {v ^ 8'hC3, ~v, v, v + 8'd1};
            exp_q.push_back({v, w});
            stim.push_back(w[7:0]);
            stim.push_back(w[15:8]);
            stim.push_back(w[23:16]);
            stim.push_back(w[31:24]);
        end
        send_stream(0);
        load_end(8'hFF, {8'hFF ^ 8'hC3, 8'h00, 8'hFF, 8'h00});
        drain();

        // reset in the middle of a word, then a one-word load
        do_reset();
        stim = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        send_stream(0);
        do_reset();
        exp_q.push_back({8'h00, 32'h44332211});
        stim = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_stream(1);
        load_end(8'h00, 32'h44332211);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the processor's instruction memory and holds the CPU in reset until a program is written. It takes a byte stream over a valid/ready handshake, typically from a UART receiver. It reads a 16-bit word-count header, packs the following bytes little-endian into 32-bit instruction words, and writes them to instruction-memory addresses 0..N-1. It then releases the CPU. Malformed headers leave the CPU in reset and flag an error.

## Interface
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity 2^ADDR_WIDTH words.

- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rxData  in  8  incoming byte.
- rxValid  in  1  rxData valid.
- rxReady  out  1  loader accepts a byte this cycle; a transfer occurs on a rising edge with rxValid & rxReady.
- imemWrAddr  out  ADDR_WIDTH  instruction-memory word address.
- imemWrData  out  32  instruction word.
- imemWrEnable  out  1  one-cycle write strobe.
- cpuRst  out  1  CPU reset; high until loading completes.
- done  out  1  program loaded, CPU released.
- error  out  1  header rejected; sticky until rst.

## Operation
- FSM states: HDR_LO, HDR_HI, CHECK, DATA, WRITE, DONE, ERROR. All outputs are registered.
- HDR_LO: rxReady=1. On transfer, latch count[7:0] and go to HDR_HI.
- HDR_HI: rxReady=1. On transfer, latch count[15:8] and go to CHECK.
- CHECK: rxReady=0. If count==0 or count>2^ADDR_WIDTH, go to ERROR; otherwise go to DATA with wordIdx=0 and byteIdx=0.
- DATA: rxReady=1. Each transfer places rxData in bits [8*byteIdx+7 : 8*byteIdx], then byteIdx is incremented. On the transfer with byteIdx==3, go to WRITE.
- WRITE: rxReady=0, imemWrEnable=1, imemWrAddr=wordIdx, imemWrData=assembled word. Next state:
  - if wordIdx==count-1, go to DONE;
  - otherwise wordIdx+1 and go to DATA.
- DONE: rxReady=0, cpuRst=0, done=1. Incoming bytes are ignored and not consumed. The FSM stays here until rst.
- ERROR: rxReady=0, cpuRst=1, error=1. The FSM stays here until rst.
- Count and comparisons use 17-bit arithmetic, so count=2^ADDR_WIDTH is legal. wordIdx never wraps; the last address is 2^ADDR_WIDTH-1.
- imemWrAddr and imemWrData hold their last values outside WRITE. They are don't-care to memory because imemWrEnable=0.

## Timing
- Reset values, applied asynchronously on rst:
  - state=HDR_LO, rxReady=0, imemWrEnable=0, imemWrAddr=0, imemWrData=0, cpuRst=1, done=0, error=0.
  - count, wordIdx and byteIdx are 0.
- rxReady rises in the first clock after rst deasserts.
- Fourth byte of a word accepted at edge k: WRITE is active for cycle k..k+1 and the memory latches the word at edge k+1. rxReady is low for exactly that one cycle, so a byte presented then is held off by the source, not dropped.
- Sustained throughput: 4 bytes per 5 cycles.
- Last WRITE cycle is followed immediately by cpuRst=0 and done=1 on the next cycle. The CPU sees its first un-reset edge one cycle after the final memory write.
- Second header byte accepted at edge k: CHECK is active during the following cycle, and error is high from edge k+2.
- rst asserted mid-operation discards partial words and the count. Words already written stay in memory. The next load restarts at HDR_LO.
- rxValid gaps of any length at any state are legal and only stall the FSM.

## Structure
- Shared package holds:
  - state enum;
  - BYTE_WIDTH=8, INSN_WIDTH=32, HDR_BYTES=2;
  - byte-index type (2 bits);
  - the max-count function 2^ADDR_WIDTH.
- One sub-module, imem_loader_packer: 32-bit assembly register plus 2-bit byte index, with clear, load-byte and word-complete outputs. The top level holds the FSM, count and wordIdx.

## Test plan
- Valid two-word load: bytes 02 00 78 56 34 12 EF BE AD DE, rxValid continuous. Required: writes addr0=0x12345678 and addr1=0xDEADBEEF, and cpuRst 1→0 with done=1 one cycle after the second imemWrEnable.
- Backpressure and gaps: same stream with random 0–3 idle cycles and the byte held stable across the WRITE cycle. Required: identical writes, no byte lost or duplicated, rxReady=0 only during CHECK/WRITE.
- Zero count: bytes 00 00. Required: error=1 two cycles after the second byte, cpuRst stays 1, rxReady stays 0, no writes.
- Oversize count, ADDR_WIDTH=8: bytes 01 01 (257). Required: error=1 and no writes. Bytes 00 01 (256) followed by 1024 data bytes: last write at addr 0xFF, done=1, no wrap to 0.
- Reset mid-word: assert rst after 02 00 AA BB. Required: immediate reset values, including cpuRst=1. Then send 01 00 11 22 33 44: single write addr0=0x44332211, done=1.
- Post-done input: after a completed load, drive rxValid=1 with arbitrary bytes. Required: rxReady=0, no imemWrEnable, done and cpuRst unchanged.
